mips_debug_ctrl: RTL and testbench
==================================

MIPS_DEBUG_CTRL -- requirements
Module: mips_debug_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 500000, meaning stable-cycle count required to accept a key level change.
REQ-002 SHALL have parameter RUN_DIV, default 25000000, meaning clock cycles between core_en pulses in run mode (>=2).
REQ-003 SHALL have port clock  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port step_key  input  1  raw active-low pushbutton; press = single step.
REQ-006 SHALL have port scan_key  input  1  raw active-low pushbutton; press = capture register reg_sel.
REQ-007 SHALL have port run_sw  input  1  level; 1 = free-run, 0 = single-step mode.
REQ-008 SHALL have port bp_en  input  1  breakpoint enable.
REQ-009 SHALL have port bp_addr  input  32  breakpoint PC.
REQ-010 SHALL have port pc  input  32  current core PC.
REQ-011 SHALL have port reg_sel  input  5  register index to capture.
REQ-012 SHALL have port reg_data  input  32  core register-file read data for reg_addr, combinational.
REQ-013 SHALL have port core_en  output  1  one-cycle clock-enable pulse advancing the core one instruction.
REQ-014 SHALL have port reg_addr  output  5  register-file read address to core.
REQ-015 SHALL have port disp_value  output  32  last captured register value.
REQ-016 SHALL have port halted  output  1  high while in HALT state.
REQ-017 SHALL have port step_count  output  32  number of core_en pulses issued.

Function
REQ-018 Each key SHALL pass through a 2-flop synchronizer, then a debouncer accepting a new level only after DB_CYCLES consecutive equal samples; a press event is a one-cycle pulse on accepted 1->0.
REQ-019 Control FSM states: STEP, RUN, HALT.
  - STEP: each step press -> exactly one core_en pulse, one cycle after the debounced press; run_sw=1 -> RUN.
  - RUN: divider counts 0..RUN_DIV-1; core_en at terminal count; run_sw=0 -> STEP, divider cleared.
  - HALT: no core_en; entered from RUN when bp_en=1 and pc==bp_addr, checked before each pulse, so the matching instruction is not executed.
  - Leaving HALT: run_sw=0 -> STEP. A step press in HALT issues one core_en and stays in HALT.
REQ-020 Breakpoint SHALL NOT apply in STEP mode; stepping onto bp_addr is allowed.
REQ-021 Scan FSM states: S_IDLE, S_ADDR, S_CAP.
  - S_IDLE: on scan press, go to S_ADDR.
  - S_ADDR: reg_addr <= reg_sel.
  - S_CAP: disp_value <= reg_data; return to S_IDLE.
  - Latency: disp_value updates 2 cycles after the press pulse.
REQ-022 core_en SHALL be suppressed while scan FSM is not S_IDLE. A pulse due in that window becomes pending (max one) and issues on the first cycle back in S_IDLE. Presses during a busy scan are dropped.
REQ-023 step_count SHALL increment by 1 per core_en and wrap 0xFFFFFFFF -> 0.
REQ-024 Simultaneous step press and scan press SHALL start the scan; the step becomes pending per REQ-022.

Reset
REQ-025 reset SHALL give:
  - control FSM = STEP if run_sw=0, else RUN; scan FSM = S_IDLE
  - core_en=0, reg_addr=0, disp_value=0, halted=0, step_count=0
  - divider, pending flag and debouncers cleared (debounced level = released)
REQ-026 reset mid-scan or mid-debounce SHALL abandon the operation; no late capture or pulse.

Structure
REQ-027 Package mips_dbg_pkg SHALL hold the control and scan state enums, the 32-bit data width and the 5-bit register-address width.
REQ-028 Sub-module key_debounce (synchronizer + debouncer + press pulse, parameter DB_CYCLES) SHALL be instantiated once per key.

Verification (DB_CYCLES=4, RUN_DIV=3)
REQ-029 STEP mode, 3 step presses held 6 cycles each -> exactly 3 core_en pulses; step_count=3.
REQ-030 step_key glitch low for 2 cycles -> no core_en.
REQ-031 RUN, bp_en=1, bp_addr=0x0000000C, pc advancing by 4 from 0 -> pulses at pc 0, 4, 8; halted=1 at pc=0x0C; step_count=3.
REQ-032 reg_sel=5, reg_data=0xDEADBEEF at reg_addr=5, scan press -> disp_value=0xDEADBEEF 2 cycles after pulse.
REQ-033 RUN pulse due during S_ADDR -> core_en delayed to first S_IDLE cycle; total pulse count unchanged.
REQ-034 step_count preset via 0xFFFFFFFF pulses (forced) + 1 step -> step_count=0; reset mid-S_ADDR -> disp_value=0.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared widths and state encodings for the MIPS debug controller.
package mips_dbg_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    CTRL_STEP = 2'd0,
    CTRL_RUN  = 2'd1,
    CTRL_HALT = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_CAP  = 2'd2
  } scan_state_t;
endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, level debouncer,
// and a one-cycle press pulse on an accepted released->pressed change.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive samples have disagreed with level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/mips_debug_ctrl.sv
// Debug front end for a MIPS core: single-step / free-run / breakpoint halt
// control of core_en, plus a register scan-out path to disp_value.
module mips_debug_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int RUN_DIV   = 25000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step_key,
  input  logic              scan_key,
  input  logic              run_sw,
  input  logic              bp_en,
  input  logic [DATA_W-1:0] bp_addr,
  input  logic [DATA_W-1:0] pc,
  input  logic [REG_AW-1:0] reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              core_en,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DATA_W-1:0] disp_value,
  output logic              halted,
  output logic [DATA_W-1:0] step_count
);
  localparam int DW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  logic        step_press;
  logic        scan_press;
  ctrl_state_t ctrl_state, ctrl_next;
  scan_state_t scan_state, scan_next;
  logic [DW-1:0] div, div_next;
  logic        pending, pending_next;
  logic        want;
  logic        scan_busy;
  logic        fire;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_key (
    .clock (clock),
    .reset (reset),
    .key_n (step_key),
    .press (step_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_scan_key (
    .clock (clock),
    .reset (reset),
    .key_n (scan_key),
    .press (scan_press)
  );

  always_comb begin
    ctrl_next = ctrl_state;
    div_next  = div;
    want      = 1'b0;
    case (ctrl_state)
      CTRL_STEP: begin
        want     = step_press;
        div_next = '0;
        if (run_sw) ctrl_next = CTRL_RUN;
      end
      CTRL_RUN: begin
        if (!run_sw) begin
          ctrl_next = CTRL_STEP;
          div_next  = '0;
        end else if (div == DIV_LAST) begin
          div_next = '0;
          // Breakpoint is tested before the pulse, so the matching
          // instruction is never executed.
          if (bp_en && (pc == bp_addr)) ctrl_next = CTRL_HALT;
          else                          want      = 1'b1;
        end else begin
          div_next = div + DW'(1);
        end
      end
      CTRL_HALT: begin
        want     = step_press;
        div_next = '0;
        if (!run_sw) ctrl_next = CTRL_STEP;
      end
      default: begin
        ctrl_next = CTRL_STEP;
        div_next  = '0;
      end
    endcase
  end

  always_comb begin
    scan_next = scan_state;
    case (scan_state)
      S_IDLE:  if (scan_press) scan_next = S_ADDR;
      S_ADDR:  scan_next = S_CAP;
      S_CAP:   scan_next = S_IDLE;
      default: scan_next = S_IDLE;
    endcase
  end

  // core_en is registered, so a pulse is blocked whenever the cycle it
  // would occupy belongs to an active scan; at most one is held over.
  always_comb begin
    scan_busy    = (scan_next != S_IDLE);
    fire         = !scan_busy && (want || pending);
    pending_next = scan_busy && (want || pending);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_state <= run_sw ? CTRL_RUN : CTRL_STEP;
      scan_state <= S_IDLE;
      div        <= '0;
      pending    <= 1'b0;
      core_en    <= 1'b0;
      reg_addr   <= '0;
      disp_value <= '0;
      step_count <= '0;
    end else begin
      ctrl_state <= ctrl_next;
      scan_state <= scan_next;
      div        <= div_next;
      pending    <= pending_next;
      core_en    <= fire;
      if (fire) step_count <= step_count + 32'd1;
      if (scan_next == S_ADDR) reg_addr <= reg_sel;
      if (scan_next == S_CAP) disp_value <= reg_data;
    end
  end

  assign halted = (ctrl_state == CTRL_HALT);
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed bench for mips_debug_ctrl with short debounce and run periods.
module tb_mips_debug_ctrl;
  logic        clock;
  logic        reset;
  logic        step_key;
  logic        scan_key;
  logic        run_sw;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        core_en;
  logic [4:0]  reg_addr;
  logic [31:0] disp_value;
  logic        halted;
  logic [31:0] step_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pulse_cnt = '0;
  logic [31:0] pulse_mark = '0;
  logic [31:0] base;

  mips_debug_ctrl #(.DB_CYCLES(4), .RUN_DIV(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .step_key   (step_key),
    .scan_key   (scan_key),
    .run_sw     (run_sw),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data),
    .core_en    (core_en),
    .reg_addr   (reg_addr),
    .disp_value (disp_value),
    .halted     (halted),
    .step_count (step_count)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core stand-ins: pc advances 4 per executed instruction, register file
  // returns a recognisable pattern per index.
  assign pc       = (pulse_cnt - pulse_mark) << 2;
  assign reg_data = (reg_addr == 5'd5) ? 32'hDEADBEEF : (32'hA5A50000 | {27'd0, reg_addr});

  always @(negedge clock) if (core_en === 1'b1) pulse_cnt <= pulse_cnt + 32'd1;

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic do_reset(input logic rs);
    wait_cycles(1);
    reset  = 1'b1;
    run_sw = rs;
    wait_cycles(1);
    reset  = 1'b0;
  endtask

  task automatic press_step();
    step_key = 1'b0;
    wait_cycles(6);
    step_key = 1'b1;
    wait_cycles(12);
  endtask

  task automatic press_scan();
    scan_key = 1'b0;
    wait_cycles(6);
    scan_key = 1'b1;
    wait_cycles(12);
  endtask

  // Tests
  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en: got %b expected 0", core_en); end
    checks++; if (reg_addr !== 5'd0) begin errors++; $display("FAIL reset_reg_addr: got %h expected 00", reg_addr); end
    checks++; if (disp_value !== 32'd0) begin errors++; $display("FAIL reset_disp: got %h expected 00000000", disp_value); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (step_count !== 32'd0) begin errors++; $display("FAIL reset_step_count: got %h expected 00000000", step_count); end
  endtask

  task automatic test_step();
    base = pulse_cnt;
    step_key = 1'b0;
    wait_cycles(6);
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL step_latency_early: got %b expected 0", core_en); end
    step_key = 1'b1;
    wait_cycles(1);
    checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL step_latency_pulse: got %b expected 1", core_en); end
    wait_cycles(12);
    press_step();
    press_step();
    checks++; if (pulse_cnt - base !== 32'd3) begin errors++; $display("FAIL step_pulses: got %0d expected 3", pulse_cnt - base); end
    checks++; if (step_count !== 32'd3) begin errors++; $display("FAIL step_count3: got %0d expected 3", step_count); end
  endtask

  task automatic test_glitch();
    base = pulse_cnt;
    step_key = 1'b0;
    wait_cycles(2);
    step_key = 1'b1;
    wait_cycles(15);
    checks++; if (pulse_cnt - base !== 32'd0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulse_cnt - base); end
    checks++; if (step_count !== 32'd3) begin errors++; $display("FAIL glitch_count: got %0d expected 3", step_count); end
  endtask

  task automatic test_breakpoint();
    bp_en      = 1'b1;
    bp_addr    = 32'h0000000C;
    pulse_mark = pulse_cnt;
    do_reset(1'b1);
    wait_cycles(20);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL bp_halted: got %b expected 1", halted); end
    checks++; if (pulse_cnt - pulse_mark !== 32'd3) begin errors++; $display("FAIL bp_pulses: got %0d expected 3", pulse_cnt - pulse_mark); end
    checks++; if (step_count !== 32'd3) begin errors++; $display("FAIL bp_step_count: got %0d expected 3", step_count); end
    press_step();
    checks++; if (pulse_cnt - pulse_mark !== 32'd4) begin errors++; $display("FAIL halt_step_pulses: got %0d expected 4", pulse_cnt - pulse_mark); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_step_stays: got %b expected 1", halted); end
    run_sw = 1'b0;
    wait_cycles(2);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_leave: got %b expected 0", halted); end
    bp_addr = 32'h00000010;
    press_step();
    checks++; if (pulse_cnt - pulse_mark !== 32'd5) begin errors++; $display("FAIL step_onto_bp: got %0d expected 5", pulse_cnt - pulse_mark); end
    checks++; if (step_count !== 32'd5) begin errors++; $display("FAIL step_onto_bp_count: got %0d expected 5", step_count); end
    bp_en = 1'b0;
  endtask

  task automatic test_scan();
    base    = pulse_cnt;
    reg_sel = 5'd5;
    scan_key = 1'b0;
    wait_cycles(6);
    scan_key = 1'b1;
    checks++; if (disp_value !== 32'd0) begin errors++; $display("FAIL scan_early: got %h expected 00000000", disp_value); end
    wait_cycles(1);
    checks++; if (reg_addr !== 5'd5) begin errors++; $display("FAIL scan_addr: got %h expected 05", reg_addr); end
    checks++; if (disp_value !== 32'd0) begin errors++; $display("FAIL scan_addr_disp: got %h expected 00000000", disp_value); end
    wait_cycles(1);
    checks++; if (disp_value !== 32'hDEADBEEF) begin errors++; $display("FAIL scan_capture: got %h expected deadbeef", disp_value); end
    wait_cycles(12);
    reg_sel = 5'd9;
    press_scan();
    checks++; if (disp_value !== 32'hA5A50009) begin errors++; $display("FAIL scan_second: got %h expected a5a50009", disp_value); end
    checks++; if (pulse_cnt - base !== 32'd0) begin errors++; $display("FAIL scan_no_pulse: got %0d expected 0", pulse_cnt - base); end
  endtask

  task automatic test_run_defer();
    base    = pulse_cnt;
    reg_sel = 5'd3;
    do_reset(1'b1);
    wait_cycles(1);
    scan_key = 1'b0;
    wait_cycles(6);
    scan_key = 1'b1;
    wait_cycles(2);
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL defer_blocked: got %b expected 0", core_en); end
    wait_cycles(1);
    checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL defer_issue: got %b expected 1", core_en); end
    wait_cycles(11);
    checks++; if (pulse_cnt - base !== 32'd7) begin errors++; $display("FAIL defer_total: got %0d expected 7", pulse_cnt - base); end
    checks++; if (disp_value !== 32'hA5A50003) begin errors++; $display("FAIL defer_disp: got %h expected a5a50003", disp_value); end
    run_sw = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    base     = pulse_cnt;
    reg_sel  = 5'd7;
    step_key = 1'b0;
    scan_key = 1'b0;
    wait_cycles(6);
    step_key = 1'b1;
    scan_key = 1'b1;
    wait_cycles(2);
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL both_blocked: got %b expected 0", core_en); end
    checks++; if (disp_value !== 32'hA5A50007) begin errors++; $display("FAIL both_disp: got %h expected a5a50007", disp_value); end
    wait_cycles(1);
    checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL both_pending_issue: got %b expected 1", core_en); end
    wait_cycles(12);
    checks++; if (pulse_cnt - base !== 32'd1) begin errors++; $display("FAIL both_pulses: got %0d expected 1", pulse_cnt - base); end
    checks++; if (step_count !== 32'd1) begin errors++; $display("FAIL both_count: got %0d expected 1", step_count); end
  endtask

  task automatic test_wrap();
    force dut.step_count = 32'hFFFFFFFF;
    wait_cycles(1);
    release dut.step_count;
    wait_cycles(1);
    checks++; if (step_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_preset: got %h expected ffffffff", step_count); end
    press_step();
    checks++; if (step_count !== 32'd0) begin errors++; $display("FAIL wrap_zero: got %h expected 00000000", step_count); end
  endtask

  task automatic test_reset_mid();
    base     = pulse_cnt;
    reg_sel  = 5'd5;
    step_key = 1'b0;
    scan_key = 1'b0;
    wait_cycles(6);
    step_key = 1'b1;
    scan_key = 1'b1;
    wait_cycles(1);
    checks++; if (reg_addr !== 5'd5) begin errors++; $display("FAIL mid_addr: got %h expected 05", reg_addr); end
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    checks++; if (disp_value !== 32'd0) begin errors++; $display("FAIL mid_disp: got %h expected 00000000", disp_value); end
    checks++; if (reg_addr !== 5'd0) begin errors++; $display("FAIL mid_reg_addr: got %h expected 00", reg_addr); end
    wait_cycles(15);
    checks++; if (disp_value !== 32'd0) begin errors++; $display("FAIL mid_no_late_capture: got %h expected 00000000", disp_value); end
    step_key = 1'b0;
    wait_cycles(3);
    reset    = 1'b1;
    step_key = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(15);
    checks++; if (pulse_cnt - base !== 32'd0) begin errors++; $display("FAIL mid_no_pulse: got %0d expected 0", pulse_cnt - base); end
    checks++; if (step_count !== 32'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", step_count); end
  endtask

  initial begin
    reset    = 1'b1;
    step_key = 1'b1;
    scan_key = 1'b1;
    run_sw   = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = '0;
    reg_sel  = '0;
    test_reset();
    test_step();
    test_glitch();
    test_breakpoint();
    test_scan();
    test_run_defer();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
